ram_sdp_be: RTL

Parametrised simple-dual-port synchronous RAM: one write port, one read port, per-byte write enables, a selectable read-during-write policy and an optional output pipeline register. After reset, a built-in clear engine fills every word with a fixed value. It succeeds the single-port RAM used on the memory test path and is the storage element for later stack and FIFO blocks. The read address is echoed with the data so downstream logic can tag results.

---
 rtl/ram_sdp_be.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ram_sdp_be.sv
`default_nettype none
// ============================================================================
// Module  : ram_sdp_be
// Brief   : Simple-dual-port synchronous RAM with byte enables, selectable
//           read-during-write policy, optional output register and a
//           post-reset clear engine.
// Revision: 1.0 - initial release
// ============================================================================
module ram_sdp_be #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    RDW_MODE    = 0,
    parameter int                    OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_n,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [ADDR_WIDTH-1:0]   rd_addr_out,
    output logic                    busy
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam int                    NBYTES   = DATA_WIDTH / 8;
    localparam logic [0:0]            ST_CLEAR = 1'b0;
    localparam logic [0:0]            ST_RUN   = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic w_busy;
    logic w_clr_wr;
    logic w_wr_acc;
    logic w_rd_acc;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_merged;
    logic [DATA_WIDTH-1:0] w_rd_sample;

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    // ------------------------------------------------------------------
    // Clear / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
        w_busy   = (state_q == ST_CLEAR);
        w_clr_wr = w_busy && !rst;
        w_wr_acc = !w_busy && !rst && !we_n;
        w_rd_acc = !w_busy && !rst && rd_en;
    end

    assign busy = w_busy;

    // ------------------------------------------------------------------
    // Storage: the clear engine and the user write port share one port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            mem_q[ptr_q] <= CLEAR_VALUE;
        end else if (w_wr_acc) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read sampling and read-during-write policy
    // ------------------------------------------------------------------
    assign w_rd_word = mem_q[rd_addr];

    always_comb begin
        w_rd_merged = w_rd_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) begin
                w_rd_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    generate
        if (RDW_MODE != 0) begin : g_rdw_new
            // Forward the byte-merged write word on a same-address collision
            assign w_rd_sample = (w_wr_acc && (wr_addr == rd_addr)) ? w_rd_merged : w_rd_word;
        end else begin : g_rdw_old
            logic [DATA_WIDTH-1:0] w_unused_merge;
            assign w_unused_merge = w_rd_merged;
            assign w_rd_sample    = w_rd_word;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage(s); data and address hold between valid reads
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s1_data_q;
            logic                  s1_valid_q;
            logic [ADDR_WIDTH-1:0] s1_addr_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_data_q  <= '0;
                    s1_valid_q <= 1'b0;
                    s1_addr_q  <= '0;
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                    rd_addr_q  <= '0;
                end else begin
                    s1_valid_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        s1_data_q <= w_rd_sample;
                        s1_addr_q <= rd_addr;
                    end
                    rd_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        rd_data_q <= s1_data_q;
                        rd_addr_q <= s1_addr_q;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                    rd_addr_q  <= '0;
                end else begin
                    rd_valid_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        rd_data_q <= w_rd_sample;
                        rd_addr_q <= rd_addr;
                    end
                end
            end
        end
    endgenerate

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_addr_out = rd_addr_q;

endmodule
`default_nettype wire
